// File: rtl/iecdrv_rom_arbiter_if.sv
// Bus bundle between the shared drive-ROM arbiter, the per-drive CPU ROM buses
// and the shared ROM read port.
interface iecdrv_rom_arbiter_if #(
    parameter int DRIVES = 2,
    parameter int AW     = 15,
    parameter int DW     = 8
);
    logic                 ph2_f;
    logic [DRIVES-1:0]    drv_en;
    logic [DRIVES*AW-1:0] drv_addr;
    logic [DRIVES*DW-1:0] drv_data;
    logic [DRIVES-1:0]    drv_valid;
    logic [AW-1:0]        mem_a;
    logic [DW-1:0]        mem_q;
    logic                 busy;
    logic                 overrun;

    // master: drive CPUs plus the ROM instance; slave: the arbiter itself
    modport master (
        output ph2_f, drv_en, drv_addr, mem_q,
        input  drv_data, drv_valid, mem_a, busy, overrun
    );

    modport slave (
        input  ph2_f, drv_en, drv_addr, mem_q,
        output drv_data, drv_valid, mem_a, busy, overrun
    );
endinterface

// File: rtl/iecdrv_rom_arbiter.sv
// Time-slot arbiter sharing one synchronous drive-ROM read port among up to
// eight drive CPUs; each ph2_f strobe issues one read per drive slot.
module iecdrv_rom_arbiter #(
    parameter int DRIVES = 2,
    parameter int AW     = 15,
    parameter int DW     = 8,
    parameter int LAT    = 1
) (
    input  logic                clk,
    input  logic                reset,
    iecdrv_rom_arbiter_if.slave bus
);
    localparam int SW = $clog2(DRIVES + 1);
    localparam int IW = (DRIVES > 1) ? $clog2(DRIVES) : 1;
    localparam logic [SW-1:0] SLOT_IDLE = SW'(DRIVES);

    if (DRIVES < 1 || DRIVES > 8 || LAT < 1 || LAT > 3) begin : g_param_check
        $error("iecdrv_rom_arbiter: DRIVES must be 1..8 and LAT 1..3");
    end

    logic [SW-1:0]        r_slot;
    logic [AW-1:0]        r_mem_a;
    logic [LAT:0]         r_vld_p;
    logic [IW-1:0]        r_idx_p [LAT+1];
    logic [DRIVES*DW-1:0] r_drv_data;
    logic [DRIVES-1:0]    r_drv_valid;
    logic                 r_overrun;

    logic [SW-1:0]        w_issue_slot;
    logic [SW-1:0]        w_slot_nxt;
    logic                 w_issue;
    logic [AW-1:0]        w_issue_addr;
    logic [DRIVES-1:0]    w_cap;
    logic                 w_busy;

    // A ph2_f strobe issues slot 0 on the very edge that samples it.
    always_comb begin
        w_issue_slot = bus.ph2_f ? '0 : r_slot;
        w_issue      = (w_issue_slot < SLOT_IDLE);
        w_slot_nxt   = w_issue ? (w_issue_slot + SW'(1)) : r_slot;
        w_issue_addr = r_mem_a;
        for (int i = 0; i < DRIVES; i++) begin
            if (w_issue && (w_issue_slot == SW'(i))) begin
                w_issue_addr = bus.drv_addr[i*AW +: AW];
            end
        end
    end

    always_comb begin
        w_cap = '0;
        for (int i = 0; i < DRIVES; i++) begin
            w_cap[i] = r_vld_p[LAT] && (r_idx_p[LAT] == IW'(i)) && bus.drv_en[i];
        end
    end

    assign w_busy = (r_slot < SLOT_IDLE) || (|r_vld_p);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot      <= SLOT_IDLE;
            r_mem_a     <= '0;
            r_vld_p     <= '0;
            for (int k = 0; k <= LAT; k++) begin
                r_idx_p[k] <= '0;
            end
            r_drv_data  <= '0;
            r_drv_valid <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_slot     <= w_slot_nxt;
            r_mem_a    <= w_issue_addr;
            // stage p0: tag travels alongside the address it was issued with
            r_vld_p[0] <= w_issue;
            r_idx_p[0] <= w_issue_slot[IW-1:0];
            for (int k = 1; k <= LAT; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
                r_idx_p[k] <= r_idx_p[k-1];
            end
            // stage pLAT: tag lines up with mem_q, capture into the drive slice
            for (int i = 0; i < DRIVES; i++) begin
                if (w_cap[i]) begin
                    r_drv_data[i*DW +: DW] <= bus.mem_q;
                end
            end
            r_drv_valid <= w_cap;
            r_overrun   <= r_overrun | (bus.ph2_f & w_busy);
        end
    end

    assign bus.mem_a     = r_mem_a;
    assign bus.drv_data  = r_drv_data;
    assign bus.drv_valid = r_drv_valid;
    assign bus.busy      = w_busy;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_iecdrv_rom_arbiter.sv
// Scoreboard bench for iecdrv_rom_arbiter: three instances (4 drives LAT=1,
// 4 drives LAT=3, 8 drives LAT=2) behind a ROM model q = addr[7:0] ^ 8'hA5.
`timescale 1ns/1ps
module tb_iecdrv_rom_arbiter;
    typedef struct {
        int         idx;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iecdrv_rom_arbiter_if #(.DRIVES(4), .AW(16), .DW(8)) a_if();
    iecdrv_rom_arbiter_if #(.DRIVES(4), .AW(16), .DW(8)) b_if();
    iecdrv_rom_arbiter_if #(.DRIVES(8), .AW(16), .DW(8)) c_if();

    iecdrv_rom_arbiter #(.DRIVES(4), .AW(16), .DW(8), .LAT(1)) u_a (.clk(clk), .reset(rst), .bus(a_if));
    iecdrv_rom_arbiter #(.DRIVES(4), .AW(16), .DW(8), .LAT(3)) u_b (.clk(clk), .reset(rst), .bus(b_if));
    iecdrv_rom_arbiter #(.DRIVES(8), .AW(16), .DW(8), .LAT(2)) u_c (.clk(clk), .reset(rst), .bus(c_if));

    function automatic logic [7:0] rom(input logic [15:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // ROM model: data follows the address LAT cycles later
    logic [15:0] a_d1 = '0, b_d1 = '0, b_d2 = '0, b_d3 = '0, c_d1 = '0, c_d2 = '0;
    always @(posedge clk) begin
        a_d1 <= a_if.mem_a;
        b_d1 <= b_if.mem_a;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
        c_d1 <= c_if.mem_a;
        c_d2 <= c_d1;
    end
    assign a_if.mem_q = rom(a_d1);
    assign b_if.mem_q = rom(b_d3);
    assign c_if.mem_q = rom(c_d2);

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({a_if.busy, a_if.overrun, a_if.drv_valid} !== 6'b0)
            $display("FAIL reset_a_ctrl got=%b exp=0", {a_if.busy, a_if.overrun, a_if.drv_valid});
        else n_pass++;
        n_checks++;
        if ({a_if.mem_a, a_if.drv_data} !== 48'h0)
            $display("FAIL reset_a_data got=%h exp=0", {a_if.mem_a, a_if.drv_data});
        else n_pass++;
        n_checks++;
        if ({b_if.busy, b_if.drv_data, c_if.busy, c_if.overrun, c_if.drv_data} !== '0)
            $display("FAIL reset_bc got busy_b=%b busy_c=%b ovr_c=%b exp=0", b_if.busy, c_if.busy, c_if.overrun);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        exp_t e;
        int   t0;
        a_if.drv_addr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        a_if.drv_en   = 4'hF;
        @(negedge clk);
        t0 = cyc;
        a_if.ph2_f = 1'b1;
        for (int i = 0; i < 4; i++)
            qa.push_back('{idx: i, data: rom(a_if.drv_addr[i*16 +: 16]), cyc: t0 + 3 + i});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            a_if.ph2_f = 1'b0;
            if (k == 1) a_if.drv_addr[15:0] = 16'h0077;
            n_checks++;
            if (a_if.busy !== (k <= 5)) $display("FAIL basic_busy k=%0d got=%b exp=%b", k, a_if.busy, (k <= 5));
            else n_pass++;
            if (k <= 4) begin
                n_checks++;
                if (a_if.mem_a !== 16'(16'h0010 * k)) $display("FAIL basic_mem_a k=%0d got=%h exp=%h", k, a_if.mem_a, 16'(16'h0010 * k));
                else n_pass++;
            end
            if (a_if.drv_valid !== 4'b0) begin
                n_checks++;
                if (qa.size() == 0) $display("FAIL basic_pulse unexpected cyc=%0d valid=%b exp=none", cyc, a_if.drv_valid);
                else begin
                    e = qa.pop_front();
                    if (a_if.drv_valid !== (4'b1 << e.idx) || a_if.drv_data[e.idx*8 +: 8] !== e.data || cyc !== e.cyc)
                        $display("FAIL basic_pulse cyc=%0d valid=%b data=%h exp cyc=%0d idx=%0d data=%h",
                                 cyc, a_if.drv_valid, a_if.drv_data, e.cyc, e.idx, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (qa.size() != 0) $display("FAIL basic_missing got=%0d pending exp=0", qa.size());
        else n_pass++;
        qa.delete();
        n_checks++;
        if (a_if.drv_data !== 32'hE59585B5) $display("FAIL basic_data got=%h exp=E59585B5", a_if.drv_data);
        else n_pass++;
        a_if.drv_addr[15:0] = 16'h0010;
    endtask

    task automatic test_enable();
        exp_t e;
        int   t0;
        a_if.drv_addr = {16'h0040, 16'h0031, 16'h0020, 16'h0010};
        a_if.drv_en   = 4'b1011;
        @(negedge clk);
        t0 = cyc;
        a_if.ph2_f = 1'b1;
        qa.push_back('{idx: 0, data: 8'hB5, cyc: t0 + 3});
        qa.push_back('{idx: 1, data: 8'h85, cyc: t0 + 4});
        qa.push_back('{idx: 3, data: 8'hE5, cyc: t0 + 6});
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            a_if.ph2_f = 1'b0;
            n_checks++;
            if (a_if.busy !== (k <= 5)) $display("FAIL en_busy k=%0d got=%b exp=%b", k, a_if.busy, (k <= 5));
            else n_pass++;
            if (a_if.drv_valid !== 4'b0) begin
                n_checks++;
                if (qa.size() == 0) $display("FAIL en_pulse unexpected cyc=%0d valid=%b exp=none", cyc, a_if.drv_valid);
                else begin
                    e = qa.pop_front();
                    if (a_if.drv_valid !== (4'b1 << e.idx) || a_if.drv_data[e.idx*8 +: 8] !== e.data || cyc !== e.cyc)
                        $display("FAIL en_pulse cyc=%0d valid=%b data=%h exp cyc=%0d idx=%0d data=%h",
                                 cyc, a_if.drv_valid, a_if.drv_data, e.cyc, e.idx, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (qa.size() != 0) $display("FAIL en_missing got=%0d pending exp=0", qa.size());
        else n_pass++;
        qa.delete();
        n_checks++;
        if (a_if.drv_data[23:16] !== 8'h95) $display("FAIL en_hold got=%h exp=95", a_if.drv_data[23:16]);
        else n_pass++;
        a_if.drv_en = 4'hF;
    endtask

    task automatic test_overrun();
        exp_t e;
        int   t0;
        a_if.drv_addr = {$urandom(), $urandom()};
        @(negedge clk);
        t0 = cyc;
        a_if.ph2_f = 1'b1;
        for (int i = 0; i < 3; i++)
            qa.push_back('{idx: i, data: rom(a_if.drv_addr[i*16 +: 16]), cyc: t0 + 3 + i});
        for (int i = 0; i < 4; i++)
            qa.push_back('{idx: i, data: rom(a_if.drv_addr[i*16 +: 16]), cyc: t0 + 6 + i});
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            a_if.ph2_f = (k == 3);
            n_checks++;
            if (a_if.overrun !== (k >= 4)) $display("FAIL ovr_flag k=%0d got=%b exp=%b", k, a_if.overrun, (k >= 4));
            else n_pass++;
            n_checks++;
            if (a_if.busy !== (k <= 8)) $display("FAIL ovr_busy k=%0d got=%b exp=%b", k, a_if.busy, (k <= 8));
            else n_pass++;
            if (a_if.drv_valid !== 4'b0) begin
                n_checks++;
                if (qa.size() == 0) $display("FAIL ovr_pulse unexpected cyc=%0d valid=%b exp=none", cyc, a_if.drv_valid);
                else begin
                    e = qa.pop_front();
                    if (a_if.drv_valid !== (4'b1 << e.idx) || a_if.drv_data[e.idx*8 +: 8] !== e.data || cyc !== e.cyc)
                        $display("FAIL ovr_pulse cyc=%0d valid=%b data=%h exp cyc=%0d idx=%0d data=%h",
                                 cyc, a_if.drv_valid, a_if.drv_data, e.cyc, e.idx, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (qa.size() != 0) $display("FAIL ovr_missing got=%0d pending exp=0", qa.size());
        else n_pass++;
        qa.delete();
        repeat (10) @(negedge clk);
        n_checks++;
        if (a_if.overrun !== 1'b1) $display("FAIL ovr_sticky got=%b exp=1", a_if.overrun);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t0;
        a_if.drv_addr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        @(negedge clk);
        t0 = cyc;
        a_if.ph2_f = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            a_if.ph2_f = 1'b0;
            if (k == 2) rst = 1'b1;
            if (k == 3) rst = 1'b0;
            if (k >= 3) begin
                n_checks++;
                if ({a_if.drv_valid, a_if.busy, a_if.overrun, a_if.mem_a, a_if.drv_data} !== '0)
                    $display("FAIL rstmid k=%0d got valid=%b busy=%b ovr=%b mem_a=%h data=%h exp=0",
                             k, a_if.drv_valid, a_if.busy, a_if.overrun, a_if.mem_a, a_if.drv_data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_lat3();
        exp_t e;
        int   t0;
        b_if.drv_addr = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
        b_if.drv_en   = 4'hF;
        @(negedge clk);
        t0 = cyc;
        b_if.ph2_f = 1'b1;
        for (int i = 0; i < 4; i++)
            qb.push_back('{idx: i, data: rom(b_if.drv_addr[i*16 +: 16]), cyc: t0 + 5 + i});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            b_if.ph2_f = 1'b0;
            n_checks++;
            if (b_if.busy !== (k <= 7)) $display("FAIL lat3_busy k=%0d got=%b exp=%b", k, b_if.busy, (k <= 7));
            else n_pass++;
            if (b_if.drv_valid !== 4'b0) begin
                n_checks++;
                if (qb.size() == 0) $display("FAIL lat3_pulse unexpected cyc=%0d valid=%b exp=none", cyc, b_if.drv_valid);
                else begin
                    e = qb.pop_front();
                    if (b_if.drv_valid !== (4'b1 << e.idx) || b_if.drv_data[e.idx*8 +: 8] !== e.data || cyc !== e.cyc)
                        $display("FAIL lat3_pulse cyc=%0d valid=%b data=%h exp cyc=%0d idx=%0d data=%h",
                                 cyc, b_if.drv_valid, b_if.drv_data, e.cyc, e.idx, e.data);
                    else n_pass++;
                end
            end
        end
        n_checks++;
        if (qb.size() != 0) $display("FAIL lat3_missing got=%0d pending exp=0", qb.size());
        else n_pass++;
        qb.delete();
    endtask

    task automatic test_random_d8();
        exp_t e;
        c_if.drv_en = 8'hFF;
        @(negedge clk);
        for (int n = 0; n < 100 * 16 + 16; n++) begin
            if ((n % 16 == 0) && (n < 1600)) begin
                c_if.drv_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
                c_if.ph2_f    = 1'b1;
                for (int i = 0; i < 8; i++)
                    qc.push_back('{idx: i, data: rom(c_if.drv_addr[i*16 +: 16]), cyc: cyc + 4 + i});
            end else begin
                c_if.ph2_f = 1'b0;
            end
            if (c_if.drv_valid !== 8'b0) begin
                n_checks++;
                if (qc.size() == 0) $display("FAIL d8_pulse unexpected cyc=%0d valid=%b exp=none", cyc, c_if.drv_valid);
                else begin
                    e = qc.pop_front();
                    if (c_if.drv_valid !== (8'b1 << e.idx) || c_if.drv_data[e.idx*8 +: 8] !== e.data || cyc !== e.cyc)
                        $display("FAIL d8_pulse cyc=%0d valid=%b exp cyc=%0d idx=%0d data=%h got data=%h",
                                 cyc, c_if.drv_valid, e.cyc, e.idx, e.data, c_if.drv_data[e.idx*8 +: 8]);
                    else n_pass++;
                end
            end
            if (n % 16 == 15) begin
                n_checks++;
                if (c_if.overrun !== 1'b0) $display("FAIL d8_overrun n=%0d got=%b exp=0", n, c_if.overrun);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (qc.size() != 0) $display("FAIL d8_missing got=%0d pending exp=0", qc.size());
        else n_pass++;
        qc.delete();
    endtask

    initial begin
        a_if.ph2_f = 1'b0; a_if.drv_en = 4'hF;  a_if.drv_addr = '0;
        b_if.ph2_f = 1'b0; b_if.drv_en = 4'hF;  b_if.drv_addr = '0;
        c_if.ph2_f = 1'b0; c_if.drv_en = 8'hFF; c_if.drv_addr = '0;
        test_reset();
        test_basic();
        test_enable();
        test_overrun();
        test_reset_mid();
        test_basic();
        test_lat3();
        test_random_d8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "time limit");
    end
endmodule
